io_uart_tx: RTL and testbench



---
 rtl/io_uart_pkg.sv | 22 ++
 rtl/io_uart_tx_sync_fifo.sv | 57 +++++
 rtl/io_uart_tx.sv | 170 +++++++++++++++++
 tb/tb_io_uart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/io_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// STATUS bit positions and the serialiser state type.
package io_uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_LEVEL   = 2'd3;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/io_uart_tx_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push into a full FIFO is still
// accepted when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; empty/full come from the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Bus-attached 8N1 UART transmitter: register decode with one registered
// wait state, TX FIFO and a baud-timed IDLE/START/DATA/STOP serialiser.
module io_uart_tx
  import io_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_sel,
  input  logic        io_we,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        io_ready,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  tx_state_t   state_q, state_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        tx_q, tx_d;

  logic        access, wr_acc, push, pop, busy, baud_zero;
  logic [1:0]  reg_sel;
  logic [7:0]  fifo_data;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_count;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign access    = io_sel && !ready_q;
  assign wr_acc    = access && io_we;
  assign reg_sel   = io_addr[3:2];
  assign push      = wr_acc && (reg_sel == REG_TXDATA);
  assign busy      = (state_q != ST_IDLE);
  assign baud_zero = (cnt_q == 16'd0);
  assign unused_bits = ^{io_addr[31:4], io_addr[1:0], io_wdata[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (io_wdata[7:0]),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rd_val = '0;
    unique case (reg_sel)
      REG_TXDATA:  rd_val = '0;
      REG_STATUS:  rd_val = {28'd0, ovf_q, busy, fifo_full, fifo_empty};
      REG_BAUDDIV: rd_val = {16'd0, div_q};
      REG_LEVEL:   rd_val = {{(31-AW){1'b0}}, fifo_count};
    endcase
  end

  always_comb begin
    ready_d = access;
    rdata_d = rdata_q;
    if (access) rdata_d = io_we ? 32'd0 : rd_val;
    div_d = div_q;
    if (wr_acc && (reg_sel == REG_BAUDDIV)) div_d = io_wdata[15:0];
    // Overflow set is applied last so it wins over a same-edge clear.
    ovf_d = ovf_q;
    if (wr_acc && (reg_sel == REG_STATUS) && io_wdata[STAT_OVF]) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_START;
      ST_START: if (baud_zero) state_d = ST_DATA;
      ST_DATA:  if (baud_zero && (bit_idx_q == 3'd7)) state_d = ST_STOP;
      ST_STOP:  if (baud_zero) state_d = ST_IDLE;
    endcase
  end

  // The line level for the next bit is registered on the boundary edge,
  // so tx_q always matches the state being entered.
  always_comb begin
    pop       = 1'b0;
    tx_d      = tx_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_data;
          cnt_d   = div_q;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (baud_zero) begin
          cnt_d     = div_q;
          bit_idx_d = 3'd0;
          tx_d      = shreg_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_zero) begin
          cnt_d = div_q;
          if (bit_idx_q == 3'd7) begin
            tx_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (!baud_zero) cnt_d = cnt_q - 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      div_q     <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  assign io_ready = ready_q;
  assign io_rdata = rdata_q;
  assign uart_tx  = tx_q;

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: a frame-level line model and handshake model checked
// every cycle, plus directed register accesses with literal expectations.
module tb_io_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_sel = 1'b0;
  logic        io_we = 1'b0;
  logic [31:0] io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic [31:0] io_rdata;
  logic        io_ready;
  logic        uart_tx;

  always #5 clk = ~clk;

  io_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd433)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_sel   (io_sel),
    .io_we    (io_we),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_ready (io_ready),
    .uart_tx  (uart_tx)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Model: bytes that must appear on the line, in order, and the divider in force.
  logic [7:0]  exp_q[$];
  logic [15:0] div_m = 16'd433;
  logic        ready_m = 1'b0;
  int          rx_st = 0;
  int          k = 0;
  int          period = 1;
  logic [9:0]  frame = '1;
  int          last_fall = 0;
  int          prev_fall = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_m <= 1'b0;
    else        ready_m <= io_sel && !ready_m;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_st = 0;
    end else begin
      check("io_ready", {31'd0, io_ready}, {31'd0, ready_m});
      case (rx_st)
        0: if (uart_tx == 1'b0) begin
             if (exp_q.size() == 0) begin
               n_assert++;
               n_fail++;
               $display("FAIL spurious_start: uart_tx=0 with no byte pending, required 1 (cycle %0d)", cyc);
             end else begin
               frame     = {1'b1, exp_q.pop_front(), 1'b0};
               period    = int'(div_m) + 1;
               k         = 1;
               prev_fall = last_fall;
               last_fall = cyc;
               rx_st     = 1;
             end
           end
        1: begin
             check("uart_tx_bit", {31'd0, uart_tx}, {31'd0, frame[k / period]});
             k++;
             if (k == 10 * period) rx_st = 2;
           end
        default: begin
             check("uart_tx_gap", {31'd0, uart_tx}, 32'd1);
             rx_st = 0;
           end
      endcase
    end
  end

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata);
    int n = 0;
    io_sel = 1'b1; io_we = we; io_addr = addr; io_wdata = wdata;
    do begin
      @(posedge clk); #1; n++;
    end while (!io_ready && n < 8);
    check("bus_ready_seen", {31'd0, io_ready}, 32'd1);
    rdata  = io_rdata;
    io_sel = 1'b0;
    if (we && addr[3:2] == 2'd2) div_m = wdata[15:0];
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    bus(1'b1, addr, data, d);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, addr, 32'd0, d);
    check(name, d, exp);
  endtask

  task automatic push(input logic [31:0] addr, input logic [7:0] b, input logic drop);
    wr(addr, {24'd0, b});
    if (!drop) exp_q.push_back(b);
  endtask

  task automatic wait_fall(input int max_cyc);
    int n = 0;
    while (uart_tx !== 1'b0 && n < max_cyc) begin
      @(posedge clk); #1; n++;
    end
    check("start_bit_seen", {31'd0, uart_tx}, 32'd0);
  endtask

  task automatic drain(input string name, input int max_polls);
    logic [31:0] s;
    int n = 0;
    do begin
      bus(1'b0, 32'h4, 32'd0, s); n++;
    end while (s != 32'h1 && n < max_polls);
    check({name, "_idle_status"}, s, 32'h1);
    check({name, "_all_sent"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  a5_exp;
    int          target;

    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a start bit.
    push(32'h0, 8'h3C, 1'b0);
    repeat (50) @(posedge clk);
    #2;
    check("pre_reset_line_low", {31'd0, uart_tx}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_io_ready", {31'd0, io_ready}, 32'd0);
    exp_q.delete();
    div_m = 16'd433;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_status", 32'h4, 32'h1);
    rd_chk("rst_bauddiv", 32'h8, 32'h1B1);
    rd_chk("txdata_reads_zero", 32'h0, 32'h0);
    rd_chk("rst_level", 32'hC, 32'h0);

    // Held select: a new access every other cycle.
    repeat (2) @(posedge clk);
    #1;
    io_sel = 1'b1; io_we = 1'b0; io_addr = 32'h8;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("hs_ready", {31'd0, io_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (io_ready) check("hs_rdata", io_rdata, 32'h1B1);
    end
    io_sel = 1'b0;
    @(posedge clk); #1;
    check("hs_drop", {31'd0, io_ready}, 32'd0);

    // Single frame of 0xA5 at 4 cycles per bit.
    bus(1'b1, 32'h8, 32'd3, d);
    check("wr_rdata_zero", d, 32'd0);
    push(32'h0, 8'hA5, 1'b0);
    wait_fall(10);
    a5_exp = 10'b1101001010;
    repeat (2) @(posedge clk);
    #1;
    check("a5_bit", {31'd0, uart_tx}, {31'd0, a5_exp[0]});
    for (int i = 1; i < 10; i++) begin
      repeat (4) @(posedge clk);
      #1;
      check("a5_bit", {31'd0, uart_tx}, {31'd0, a5_exp[i]});
    end
    repeat (4) @(posedge clk);
    #1;
    rd_chk("a5_status_after", 32'h4, 32'h1);

    // Back-to-back frames at one cycle per bit.
    wr(32'h8, 32'd0);
    push(32'h0, 8'h55, 1'b0);
    push(32'h0, 8'h0F, 1'b0);
    rd_chk("b2b_level", 32'hC, 32'h1);
    drain("b2b", 100);
    check("b2b_spacing", last_fall - prev_fall, 32'd11);

    // Address aliasing and upper divider bits.
    wr(32'h8, 32'hFFFF_0002);
    rd_chk("bauddiv_upper_ignored", 32'h8, 32'h2);
    push(32'h40, 8'h3C, 1'b0);
    rd_chk("alias_txdata_reads_zero", 32'h40, 32'h0);
    drain("alias", 100);

    // Push landing on the same edge as a pop from a full FIFO.
    wr(32'h8, 32'd3);
    for (int i = 0; i < 9; i++) push(32'h0, 8'h10 + 8'(i), 1'b0);
    rd_chk("pp_status_full", 32'h4, 32'h6);
    rd_chk("pp_level_full", 32'hC, 32'h8);
    target = last_fall + 41;
    while (cyc < target - 1) begin
      @(posedge clk); #1;
    end
    push(32'h0, 8'h99, 1'b0);
    check("pp_push_on_pop_edge", cyc, target);
    rd_chk("pp_status_no_ovf", 32'h4, 32'h6);
    rd_chk("pp_level_after", 32'hC, 32'h8);
    drain("pp", 400);

    // Overflow: one in flight, eight buffered, tenth dropped.
    wr(32'h8, 32'd100);
    for (int i = 0; i < 10; i++) push(32'h0, 8'hC0 + 8'(i), (i == 9));
    rd_chk("ovf_status", 32'h4, 32'hE);
    rd_chk("ovf_level", 32'hC, 32'h8);
    wr(32'h4, 32'h8);
    rd_chk("ovf_cleared", 32'h4, 32'h6);
    drain("ovf", 6000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
